// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer: FSM state encoding
// and the default Galois feedback mask for the 8-bit challenge LFSR.
package puf_challenge_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        SETTLE,
        SAMPLE,
        DONE
    } seqState_e;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Bundles the host request/response handshake and the PUF core drive/sense lines.
// The master modport is the sequencer's view; slave is the host/PUF side.
interface puf_challenge_sequencer_if #(
    parameter int C_BITS = 8,
    parameter int N_RESP = 16
);

    logic              start;
    logic [C_BITS-1:0] seed;
    logic              busy;
    logic              puf_reset;
    logic              puf_enable;
    logic [C_BITS-1:0] puf_challenge;
    logic              puf_resp;
    logic [N_RESP-1:0] resp_word;
    logic              resp_valid;
    logic              resp_ready;

    modport master (
        input  start, seed, puf_resp, resp_ready,
        output busy, puf_reset, puf_enable, puf_challenge, resp_word, resp_valid
    );

    modport slave (
        output start, seed, puf_resp, resp_ready,
        input  busy, puf_reset, puf_enable, puf_challenge, resp_word, resp_valid
    );

endinterface

// File: rtl/puf_challenge_sequencer_challenge_lfsr.sv
// Galois LFSR producing the challenge sequence; a zero seed is replaced by 1 so
// the register can never lock up in the all-zero state.
module puf_challenge_sequencer_challenge_lfsr
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int                C_BITS    = 8,
    parameter logic [C_BITS-1:0] LFSR_TAPS = DEFAULT_LFSR_TAPS
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [C_BITS-1:0] seed_i,
    output logic [C_BITS-1:0] challenge_o
);

    logic [C_BITS-1:0] lfsr_q;
    logic [C_BITS-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? C_BITS'(1) : seed_i;
        end else if (step_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign challenge_o = lfsr_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs N_RESP clear/arm/settle/sample evaluations of an arbiter PUF over an LFSR
// challenge sequence and hands the packed response word downstream.
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int                C_BITS        = 8,
    parameter int                N_RESP        = 16,
    parameter int                SETTLE_CYCLES = 4,
    parameter logic [C_BITS-1:0] LFSR_TAPS     = DEFAULT_LFSR_TAPS
) (
    input logic                       clk_i,
    input logic                       reset_i,
    puf_challenge_sequencer_if.master seqIf
);

    localparam int BIT_W    = (N_RESP > 1) ? $clog2(N_RESP) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);

    seqState_e           state_q,     state_d;
    logic [BIT_W-1:0]    bitCnt_q,    bitCnt_d;
    logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
    logic [N_RESP-1:0]   respWord_q,  respWord_d;
    logic                pufReset_q,  pufReset_d;
    logic                pufEnable_q, pufEnable_d;
    logic                busy_q,      busy_d;
    logic                respValid_q, respValid_d;
    logic                syncMeta_q;
    logic                syncResp_q;
    logic                lfsrLoad;
    logic                lfsrStep;
    logic [C_BITS-1:0]   challenge;

    puf_challenge_sequencer_challenge_lfsr #(
        .C_BITS    (C_BITS),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (lfsrLoad),
        .step_i      (lfsrStep),
        .seed_i      (seqIf.seed),
        .challenge_o (challenge)
    );

    // The PUF response is raced asynchronously, so only the second flop is ever used.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            syncMeta_q <= 1'b0;
            syncResp_q <= 1'b0;
        end else begin
            syncMeta_q <= seqIf.puf_resp;
            syncResp_q <= syncMeta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        settleCnt_d = settleCnt_q;
        respWord_d  = respWord_q;
        lfsrLoad    = 1'b0;
        lfsrStep    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (seqIf.start) begin
                    lfsrLoad = 1'b1;
                    bitCnt_d = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: state_d = ARM;
            ARM: begin
                settleCnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
                state_d     = SETTLE;
            end
            SETTLE: begin
                if (settleCnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q - SETTLE_W'(1);
                end
            end
            // The challenge only steps towards another CLEAR, so it never moves while armed.
            SAMPLE: begin
                respWord_d[bitCnt_q] = syncResp_q;
                if (bitCnt_q == BIT_W'(N_RESP - 1)) begin
                    state_d = DONE;
                end else begin
                    bitCnt_d = bitCnt_q + BIT_W'(1);
                    lfsrStep = 1'b1;
                    state_d  = CLEAR;
                end
            end
            DONE: begin
                if (seqIf.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pufReset_d  = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
        pufEnable_d = (state_d == ARM) || (state_d == SETTLE);
        busy_d      = (state_d != IDLE);
        respValid_d = (state_d == DONE);
    end

    // Outputs are registered so the PUF enable/reset lines cannot glitch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            settleCnt_q <= '0;
            respWord_q  <= '0;
            pufReset_q  <= 1'b1;
            pufEnable_q <= 1'b0;
            busy_q      <= 1'b0;
            respValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            settleCnt_q <= settleCnt_d;
            respWord_q  <= respWord_d;
            pufReset_q  <= pufReset_d;
            pufEnable_q <= pufEnable_d;
            busy_q      <= busy_d;
            respValid_q <= respValid_d;
        end
    end

    assign seqIf.busy          = busy_q;
    assign seqIf.puf_reset     = pufReset_q;
    assign seqIf.puf_enable    = pufEnable_q;
    assign seqIf.puf_challenge = challenge;
    assign seqIf.resp_word     = respWord_q;
    assign seqIf.resp_valid    = respValid_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural arbiter-PUF stub
// whose response is a selectable function of the challenge.
module tb_puf_challenge_sequencer;

    localparam int C_BITS  = 8;
    localparam int N_RESP  = 16;
    localparam int SETTLE  = 4;
    localparam int LATENCY = 1 + N_RESP * (SETTLE + 3);

    logic clk;
    logic rst;
    int   pufMode;
    int   numCompared;
    int   numMismatched;
    int   enRises;

    logic [C_BITS-1:0] chExp[$];
    logic [N_RESP-1:0] wordExp[$];

    puf_challenge_sequencer_if #(.C_BITS(C_BITS), .N_RESP(N_RESP)) seqIf ();

    puf_challenge_sequencer #(
        .C_BITS        (C_BITS),
        .N_RESP        (N_RESP),
        .SETTLE_CYCLES (SETTLE),
        .LFSR_TAPS     (8'hB8)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .seqIf   (seqIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: resp = challenge[0]; mode 1: constant 1; mode 2: masked parity.
    function automatic logic stubResp(input int mode, input logic [C_BITS-1:0] c);
        if (mode == 0) return c[0];
        if (mode == 1) return 1'b1;
        return ^(c & 8'h5A);
    endfunction

    function automatic logic [C_BITS-1:0] lfsrNext(input logic [C_BITS-1:0] c);
        return (c >> 1) ^ (c[0] ? 8'hB8 : 8'h00);
    endfunction

    assign seqIf.puf_resp = seqIf.puf_enable & stubResp(pufMode, seqIf.puf_challenge);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExpected(input logic [C_BITS-1:0] s, input int mode);
        logic [C_BITS-1:0] c;
        logic [N_RESP-1:0] w;
        c = (s == '0) ? 8'h01 : s;
        w = '0;
        for (int k = 0; k < N_RESP; k++) begin
            chExp.push_back(c);
            w[k] = stubResp(mode, c);
            c    = lfsrNext(c);
        end
        wordExp.push_back(w);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},       32'(seqIf.busy),          32'h0);
        checkOutput({tag, "_puf_reset"},  32'(seqIf.puf_reset),     32'h1);
        checkOutput({tag, "_puf_enable"}, 32'(seqIf.puf_enable),    32'h0);
        checkOutput({tag, "_challenge"},  32'(seqIf.puf_challenge), 32'h0);
        checkOutput({tag, "_resp_word"},  32'(seqIf.resp_word),     32'h0);
        checkOutput({tag, "_resp_valid"}, 32'(seqIf.resp_valid),    32'h0);
    endtask

    // One full run: start pulse, wait for valid, then consume with or without backpressure.
    task automatic applyStimulus(input logic [C_BITS-1:0] seedVal, input int mode,
                                 input int hold, output logic [N_RESP-1:0] word);
        int                cycles;
        logic [N_RESP-1:0] held;
        pushExpected(seedVal, mode);
        @(posedge clk);
        #1;
        pufMode          = mode;
        seqIf.resp_ready = (hold == 0);
        seqIf.start      = 1'b1;
        seqIf.seed       = seedVal;
        @(posedge clk);
        cycles = 1;
        #1;
        seqIf.start = 1'b0;
        seqIf.seed  = 8'hFF;
        checkOutput("busy_after_start", 32'(seqIf.busy), 32'h1);
        while (!seqIf.resp_valid && cycles < 4 * LATENCY) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        word = seqIf.resp_word;
        if (!seqIf.resp_valid) begin
            checkOutput("valid_timeout", 32'h0, 32'h1);
            seqIf.resp_ready = 1'b1;
            return;
        end
        checkOutput("valid_latency", 32'(cycles), 32'(LATENCY));
        if (hold > 0) begin
            held = word;
            for (int i = 0; i < hold; i++) begin
                seqIf.start = 1'b1;
                seqIf.seed  = 8'(i + 3);
                @(posedge clk);
                #1;
                checkOutput("bp_valid", 32'(seqIf.resp_valid), 32'h1);
                checkOutput("bp_busy",  32'(seqIf.busy),       32'h1);
                checkOutput("bp_word",  32'(seqIf.resp_word),  32'(held));
            end
            seqIf.start      = 1'b0;
            seqIf.resp_ready = 1'b1;
        end else begin
            seqIf.start = 1'b1;
            seqIf.seed  = 8'h33;
        end
        @(posedge clk);
        #1;
        seqIf.start = 1'b0;
        checkOutput("release_valid", 32'(seqIf.resp_valid), 32'h0);
        checkOutput("release_busy",  32'(seqIf.busy),       32'h0);
        @(posedge clk);
        #1;
        checkOutput("idle_stays_idle", 32'(seqIf.busy), 32'h0);
    endtask

    // Protocol monitor on the falling edge: challenge scoreboard, pulse widths, word scoreboard.
    logic              prevEn;
    logic              prevRst;
    logic              prevValid;
    int                enCnt;
    int                rstCnt;
    logic [C_BITS-1:0] riseChal;

    always @(negedge clk) begin
        if (rst) begin
            prevEn    = 1'b0;
            prevRst   = 1'b1;
            prevValid = 1'b0;
            enCnt     = 0;
            rstCnt    = 0;
        end else begin
            if (seqIf.puf_enable) begin
                if (!prevEn) begin
                    riseChal = seqIf.puf_challenge;
                    enRises++;
                    if (chExp.size() > 0) begin
                        checkOutput("challenge", 32'(seqIf.puf_challenge), 32'(chExp.pop_front()));
                    end else begin
                        checkOutput("extra_eval", 32'h1, 32'h0);
                    end
                end else begin
                    checkOutput("chal_stable", 32'(seqIf.puf_challenge), 32'(riseChal));
                end
                checkOutput("no_reset_when_en", 32'(seqIf.puf_reset), 32'h0);
                enCnt++;
            end else if (prevEn) begin
                checkOutput("enable_width", 32'(enCnt), 32'(SETTLE + 1));
                enCnt = 0;
            end
            if (!seqIf.busy) begin
                rstCnt = 0;
            end else if (seqIf.puf_reset) begin
                rstCnt++;
            end else if (prevRst && rstCnt > 0) begin
                checkOutput("reset_width", 32'(rstCnt), 32'h1);
                rstCnt = 0;
            end
            if (seqIf.resp_valid && !prevValid) begin
                if (wordExp.size() > 0) begin
                    checkOutput("resp_word", 32'(seqIf.resp_word), 32'(wordExp.pop_front()));
                end else begin
                    checkOutput("unexpected_valid", 32'h1, 32'h0);
                end
            end
            prevEn    = seqIf.puf_enable;
            prevRst   = seqIf.puf_reset;
            prevValid = seqIf.resp_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_RESP-1:0] word;
        int                guard;
        numCompared      = 0;
        numMismatched    = 0;
        enRises          = 0;
        pufMode          = 0;
        seqIf.start      = 1'b0;
        seqIf.seed       = '0;
        seqIf.resp_ready = 1'b1;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkResetValues("idle");

        $display("[TB] abort a run during SETTLE of bit 3");
        pushExpected(8'h37, 2);
        @(posedge clk);
        #1;
        pufMode     = 2;
        enRises     = 0;
        seqIf.start = 1'b1;
        seqIf.seed  = 8'h37;
        @(posedge clk);
        #1;
        seqIf.start = 1'b0;
        guard = 0;
        while (enRises < 4 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("abort_reached_bit3", 32'(enRises), 32'h4);
        checkOutput("abort_enable_high", 32'(seqIf.puf_enable), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("abort");
        chExp.delete();
        wordExp.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] seed 0x01 with resp = challenge[0]");
        applyStimulus(8'h01, 0, 0, word);
        checkOutput("seed1_low6", 32'(word[5:0]), 32'b110001);

        $display("[TB] constant-one stub");
        applyStimulus(8'hA5, 1, 0, word);
        checkOutput("const1_word", 32'(word), 32'hFFFF);

        $display("[TB] zero seed substitutes 1");
        applyStimulus(8'h00, 2, 0, word);
        applyStimulus(8'h01, 2, 0, word);

        $display("[TB] backpressure for 20 cycles");
        applyStimulus(8'h5A, 2, 20, word);

        checkOutput("scoreboard_drained", 32'(wordExp.size() + chExp.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
